// File: rtl/nn_pkg.sv
// Shared widths, class encodings and FSM state naming for the perceptron inference engine.
package nn_pkg;

    localparam int XW = 7;
    localparam int WW = 14;
    localparam int CW = 8;
    localparam int AW = 2 * WW - 5;

    localparam logic [1:0] CLASS_POS = 2'b01;
    localparam logic [1:0] CLASS_NEG = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        MUL1,
        MUL2,
        RESULT
    } state_t;

    // The class depends only on the sign of the sum, so zero is classified as positive.
    function automatic logic [1:0] class_of(input logic sign_bit);
        return sign_bit ? CLASS_NEG : CLASS_POS;
    endfunction

endpackage

// File: rtl/nn_classifier_if.sv
// Sample-in / result-out valid-ready bundle of the classifier.
interface nn_classifier_if #(
    parameter int XW = nn_pkg::XW,
    parameter int AW = nn_pkg::AW
);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [XW-1:0] x1;
    logic signed [XW-1:0] x2;
    logic [1:0]           t;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           y_class;
    logic signed [AW-1:0] y_sum;

    modport master (
        output in_valid, x1, x2, t, out_ready,
        input  in_ready, out_valid, y_class, y_sum
    );

    modport slave (
        input  in_valid, x1, x2, t, out_ready,
        output in_ready, out_valid, y_class, y_sum
    );

endinterface

// File: rtl/nn_mac.sv
// Single signed XW x WW multiplier feeding an AW-bit accumulator seeded with the bias.
module nn_mac #(
    parameter int XW = nn_pkg::XW,
    parameter int WW = nn_pkg::WW,
    parameter int AW = nn_pkg::AW
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 init,
    input  logic                 add,
    input  logic signed [XW-1:0] x,
    input  logic signed [WW-1:0] w,
    input  logic signed [WW-1:0] b,
    output logic signed [AW-1:0] sum
);

    logic signed [XW+WW-1:0] prod;
    logic signed [AW-1:0]    base;
    logic signed [AW-1:0]    acc;

    assign prod = x * w;
    assign base = init ? AW'(b) : acc;
    // sum is the value the accumulator takes this cycle, visible before the edge.
    assign sum  = base + AW'(prod);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc <= '0;
        end else if (init || add) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/nn_classifier.sv
// Two-input perceptron inference: time-shared MAC, registered class/sum, saturating accuracy counters.
module nn_classifier #(
    parameter int XW = nn_pkg::XW,
    parameter int WW = nn_pkg::WW,
    parameter int CW = nn_pkg::CW
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Load,
    input  logic signed [WW-1:0] w1_in,
    input  logic signed [WW-1:0] w2_in,
    input  logic signed [WW-1:0] b_in,
    input  logic                 Clear,
    nn_classifier_if.slave       bus,
    output logic [CW-1:0]        correct_cnt,
    output logic [CW-1:0]        total_cnt
);

    localparam int AW = 2 * WW - 5;

    import nn_pkg::*;

    state_t               state;
    logic signed [WW-1:0] w1, w2, b;
    logic signed [XW-1:0] x1_r, x2_r;
    logic [1:0]           t_r;
    logic signed [XW-1:0] mac_x;
    logic signed [WW-1:0] mac_w;
    logic signed [AW-1:0] mac_sum;
    logic                 done;

    assign bus.in_ready = (state == IDLE);
    assign done         = bus.out_valid && bus.out_ready;
    assign mac_x        = (state == MUL2) ? x2_r : x1_r;
    assign mac_w        = (state == MUL2) ? w2 : w1;

    nn_mac #(.XW(XW), .WW(WW), .AW(AW)) u_mac (
        .Clk  (Clk),
        .Rst  (Rst),
        .init (state == MUL1),
        .add  (state == MUL2),
        .x    (mac_x),
        .w    (mac_w),
        .b    (b),
        .sum  (mac_sum)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.y_class   <= CLASS_POS;
            bus.y_sum     <= '0;
            w1            <= '0;
            w2            <= '0;
            b             <= '0;
            x1_r          <= '0;
            x2_r          <= '0;
            t_r           <= CLASS_POS;
        end else begin
            case (state)
                IDLE: begin
                    if (Load) begin
                        w1 <= w1_in;
                        w2 <= w2_in;
                        b  <= b_in;
                    end
                    if (bus.in_valid) begin
                        x1_r  <= bus.x1;
                        x2_r  <= bus.x2;
                        t_r   <= bus.t;
                        state <= MUL1;
                    end
                end
                MUL1: state <= MUL2;
                MUL2: begin
                    // Capture the final sum here so outputs stay frozen while the MAC is reused.
                    bus.y_sum     <= mac_sum;
                    bus.y_class   <= class_of(mac_sum[AW-1]);
                    bus.out_valid <= 1'b1;
                    state         <= RESULT;
                end
                RESULT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            correct_cnt <= '0;
            total_cnt   <= '0;
        end else if (Clear) begin
            correct_cnt <= '0;
            total_cnt   <= '0;
        end else if (done) begin
            if (total_cnt != {CW{1'b1}}) begin
                total_cnt <= total_cnt + 1'b1;
            end
            if ((bus.y_class == t_r) && (correct_cnt != {CW{1'b1}})) begin
                correct_cnt <= correct_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nn_classifier.sv
// Directed bench for nn_classifier: vector table plus hand-written handshake, race and reset sequences.
module tb_nn_classifier;
    import nn_pkg::*;

    logic                 Clk = 1'b0;
    logic                 Rst = 1'b0;
    logic                 Load = 1'b0;
    logic                 Clear = 1'b0;
    logic signed [WW-1:0] w1_in = '0;
    logic signed [WW-1:0] w2_in = '0;
    logic signed [WW-1:0] b_in = '0;
    logic [CW-1:0]        correct_cnt;
    logic [CW-1:0]        total_cnt;

    int n_checks = 0;
    int n_fail = 0;
    int m_correct = 0;
    int m_total = 0;

    nn_classifier_if bus ();

    nn_classifier dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Load        (Load),
        .w1_in       (w1_in),
        .w2_in       (w2_in),
        .b_in        (b_in),
        .Clear       (Clear),
        .bus         (bus),
        .correct_cnt (correct_cnt),
        .total_cnt   (total_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic signed [WW-1:0] w1;
        logic signed [WW-1:0] w2;
        logic signed [WW-1:0] b;
        logic signed [XW-1:0] x1;
        logic signed [XW-1:0] x2;
        logic [1:0]           t;
        logic signed [AW-1:0] y;
        logic [1:0]           cls;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_w(input logic signed [WW-1:0] w1, input logic signed [WW-1:0] w2,
                          input logic signed [WW-1:0] bb);
        w1_in = w1;
        w2_in = w2;
        b_in  = bb;
        Load  = 1'b1;
        @(posedge Clk); #1;
        Load  = 1'b0;
    endtask

    task automatic send(input string name, input logic signed [XW-1:0] x1,
                        input logic signed [XW-1:0] x2, input logic [1:0] t);
        chk({name, " in_ready before accept"}, bus.in_ready, 1);
        bus.x1 = x1;
        bus.x2 = x2;
        bus.t  = t;
        bus.in_valid = 1'b1;
        @(posedge Clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Called one step after the accepting edge; out_valid must rise in the third cycle counted from it.
    task automatic wait_result(input string name);
        int lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge Clk); #1;
            lat++;
        end
        chk({name, " latency"}, lat, 3);
        chk({name, " in_ready low with result"}, bus.in_ready, 0);
    endtask

    task automatic check_out(input string name, input logic signed [AW-1:0] y, input logic [1:0] cls);
        chk({name, " y_sum"}, bus.y_sum, y);
        chk({name, " y_class"}, bus.y_class, cls);
    endtask

    task automatic handshake(input string name, input logic [1:0] cls, input logic [1:0] t);
        bus.out_ready = 1'b1;
        @(posedge Clk); #1;
        bus.out_ready = 1'b0;
        if (m_total < 255) m_total++;
        if (cls == t && m_correct < 255) m_correct++;
        chk({name, " out_valid after accept"}, bus.out_valid, 0);
        chk({name, " total_cnt"}, total_cnt, m_total);
        chk({name, " correct_cnt"}, correct_cnt, m_correct);
    endtask

    task automatic run(input string name, input logic signed [XW-1:0] x1, input logic signed [XW-1:0] x2,
                       input logic [1:0] t, input logic signed [AW-1:0] y, input logic [1:0] cls);
        send(name, x1, x2, t);
        wait_result(name);
        check_out(name, y, cls);
        handshake(name, cls, t);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{w1: 3,     w2: -2,    b: 1,     x1: 5,   x2: 4,   t: 2'b01, y: 8,       cls: 2'b01};
        vecs[1] = '{w1: 3,     w2: -2,    b: 1,     x1: 0,   x2: 1,   t: 2'b01, y: -1,      cls: 2'b11};
        vecs[2] = '{w1: 2,     w2: 1,     b: -4,    x1: 1,   x2: 2,   t: 2'b01, y: 0,       cls: 2'b01};
        vecs[3] = '{w1: -8192, w2: -8192, b: 8191,  x1: -64, x2: -64, t: 2'b01, y: 1056767, cls: 2'b01};
        vecs[4] = '{w1: 100,   w2: -50,   b: -7,    x1: -3,  x2: 10,  t: 2'b11, y: -807,    cls: 2'b11};
        vecs[5] = '{w1: 1,     w2: 1,     b: 0,     x1: 1,   x2: 1,   t: 2'b00, y: 2,       cls: 2'b01};
        vecs[6] = '{w1: 8191,  w2: 8191,  b: 8191,  x1: -64, x2: 63,  t: 2'b11, y: 0,       cls: 2'b01};
        vecs[7] = '{w1: 8191,  w2: 8191,  b: -8192, x1: 63,  x2: 63,  t: 2'b01, y: 1023874, cls: 2'b01};

        bus.in_valid  = 1'b0;
        bus.x1        = '0;
        bus.x2        = '0;
        bus.t         = 2'b00;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge Clk);
        #1;
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset y_class", bus.y_class, 2'b01);
        chk("reset y_sum", bus.y_sum, 0);
        chk("reset correct_cnt", correct_cnt, 0);
        chk("reset total_cnt", total_cnt, 0);
        Rst = 1'b1;
        @(posedge Clk); #1;

        for (int i = 0; i < 8; i++) begin
            load_w(vecs[i].w1, vecs[i].w2, vecs[i].b);
            run($sformatf("vec%0d", i), vecs[i].x1, vecs[i].x2, vecs[i].t, vecs[i].y, vecs[i].cls);
        end
        chk("table correct_cnt", correct_cnt, 5);
        chk("table total_cnt", total_cnt, 8);

        // Backpressure with a second sample already waiting.
        load_w(3, -2, 1);
        send("bp", 5, 4, 2'b01);
        wait_result("bp");
        bus.x1 = 0;
        bus.x2 = 1;
        bus.t  = 2'b01;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("bp hold out_valid", bus.out_valid, 1);
            chk("bp hold y_sum", bus.y_sum, 8);
            chk("bp hold in_ready", bus.in_ready, 0);
            @(posedge Clk); #1;
        end
        handshake("bp first", 2'b01, 2'b01);
        chk("bp in_ready after handshake", bus.in_ready, 1);
        @(posedge Clk); #1;
        bus.in_valid = 1'b0;
        wait_result("bp second");
        check_out("bp second", -1, 2'b11);
        handshake("bp second", 2'b11, 2'b01);

        // Load during MUL2 must not disturb the sample in flight or later ones.
        send("load mul2", 5, 4, 2'b01);
        @(posedge Clk); #1;
        w1_in = 100;
        w2_in = 100;
        b_in  = 100;
        Load  = 1'b1;
        @(posedge Clk); #1;
        Load  = 1'b0;
        chk("load mul2 out_valid", bus.out_valid, 1);
        check_out("load mul2", 8, 2'b01);
        handshake("load mul2", 2'b01, 2'b01);
        run("after ignored load", 5, 4, 2'b01, 8, 2'b01);

        // Load together with in_valid: the accepted sample sees the new weights.
        w1_in = 1;
        w2_in = 1;
        b_in  = 0;
        Load  = 1'b1;
        bus.x1 = 5;
        bus.x2 = 4;
        bus.t  = 2'b01;
        bus.in_valid = 1'b1;
        @(posedge Clk); #1;
        Load = 1'b0;
        bus.in_valid = 1'b0;
        wait_result("load+valid");
        check_out("load+valid", 9, 2'b01);
        handshake("load+valid", 2'b01, 2'b01);

        // Clear coinciding with the result handshake wins.
        send("clear", 5, 4, 2'b01);
        wait_result("clear");
        Clear = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge Clk); #1;
        Clear = 1'b0;
        bus.out_ready = 1'b0;
        m_correct = 0;
        m_total = 0;
        chk("clear correct_cnt", correct_cnt, 0);
        chk("clear total_cnt", total_cnt, 0);
        chk("clear out_valid", bus.out_valid, 0);

        for (int n = 0; n < 300; n++) begin
            run("sat", 1, 1, 2'b01, 2, 2'b01);
        end
        chk("sat correct_cnt", correct_cnt, 255);
        chk("sat total_cnt", total_cnt, 255);
        run("sat miss", 1, 1, 2'b11, 2, 2'b01);

        // Asynchronous reset while the sample is in MUL1.
        send("rst mid", 5, 4, 2'b01);
        Rst = 1'b0;
        #1;
        chk("rst mid in_ready", bus.in_ready, 1);
        chk("rst mid out_valid", bus.out_valid, 0);
        chk("rst mid y_class", bus.y_class, 2'b01);
        chk("rst mid y_sum", bus.y_sum, 0);
        chk("rst mid correct_cnt", correct_cnt, 0);
        chk("rst mid total_cnt", total_cnt, 0);
        m_correct = 0;
        m_total = 0;
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;
        run("post reset", 5, 4, 2'b01, 0, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
